// File: rtl/feeder_pkg.sv
// Shared defaults, widths and FSM state encoding for the operand feeder slice.
package feeder_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int DEPTH_DEF   = 4;
    localparam int TIMEOUT_DEF = 64;
    localparam int PAIR_CNT_W  = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD1     = 3'd1,
        LOAD2     = 3'd2,
        ISSUE     = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head (rdata) and an occupancy count.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: the storage array is deliberately not reset; validity is defined by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/operand_feeder.sv
// Buffers upstream words, pairs them into (data_in1, data_in2), pulses start and
// waits for done with a timeout; one operand pair is in flight at a time.
module operand_feeder
    import feeder_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ready,
    output logic [DATA_W-1:0]     data_in1,
    output logic [DATA_W-1:0]     data_in2,
    output logic                  start,
    input  logic                  done,
    output logic                  busy,
    output logic [PAIR_CNT_W-1:0] pair_count,
    output logic                  err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int TW    = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic [DATA_W-1:0] head;
    logic [TW-1:0]     timer;
    logic              timed_out;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign fifo_pop  = ((state == LOAD1) || (state == LOAD2)) && !fifo_empty;
    assign timed_out = (timer == TIMER_LAST);

    // Decoded from the registered state so start drops as soon as reset asserts.
    assign start = (state == ISSUE);
    assign busy  = (state != IDLE);

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (in_data),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // NOTE: state registers take non-blocking assignments; the combinational block below uses blocking ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next is defaulted before the case so every path assigns it and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (fifo_count >= CNT_W'(2)) state_next = LOAD1;
            LOAD1:     state_next = LOAD2;
            LOAD2:     state_next = ISSUE;
            ISSUE:     state_next = WAIT_DONE;
            WAIT_DONE: if (done || timed_out) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Operand registers only load in LOAD1/LOAD2, so they hold through ISSUE and WAIT_DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_in1   <= '0;
            data_in2   <= '0;
            timer      <= '0;
            pair_count <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                LOAD1: data_in1 <= head;
                LOAD2: data_in2 <= head;
                ISSUE: timer <= '0;
                WAIT_DONE: begin
                    timer <= timer + 1'b1;
                    if (done) begin
                        pair_count <= pair_count + 1'b1;
                    end else if (timed_out) begin
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_feeder.sv
// Scoreboard bench for operand_feeder: accepted words form expected pairs, the
// done responder records the expected outcome of each transaction, and a monitor
// compares at every start pulse and at the end of every busy period.
`timescale 1ns/1ps
module tb_operand_feeder;

    localparam int DATA_W  = 16;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int CLK_P   = 10;

    typedef struct {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } pair_t;

    typedef struct {
        int         idx;
        logic [7:0] cnt;
        logic       flag;
    } resp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [DATA_W-1:0] data_in1;
    logic [DATA_W-1:0] data_in2;
    logic              start;
    logic              done;
    logic              busy;
    logic [7:0]        pair_count;
    logic              err;

    int checks      = 0;
    int failures    = 0;
    int starts_seen = 0;

    pair_t exp_pairs[$];
    resp_t resp_q[$];
    int    delay_q[$];

    logic [DATA_W-1:0] pend_word;
    bit                have_pend = 1'b0;
    logic [7:0]        m_count   = 8'd0;
    logic              m_err     = 1'b0;

    always #(CLK_P / 2) clk = ~clk;

    operand_feeder #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .data_in1   (data_in1),
        .data_in2   (data_in2),
        .start      (start),
        .done       (done),
        .busy       (busy),
        .pair_count (pair_count),
        .err        (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name, input string msg);
        checks++;
        failures++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // Called at a negedge; returns at the negedge after the word is accepted.
    task automatic send(input logic [DATA_W-1:0] w, input int budget);
        in_valid = 1'b1;
        in_data  = w;
        for (int n = 0; n <= budget; n++) begin
            if (in_ready) begin
                @(posedge clk);
                if (have_pend) begin
                    exp_pairs.push_back('{a: pend_word, b: w});
                    have_pend = 1'b0;
                end else begin
                    pend_word = w;
                    have_pend = 1'b1;
                end
                @(negedge clk);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        note_fail("send_accept", $sformatf("word 0x%0h never accepted", w));
    endtask

    task automatic wait_idle(input int budget);
        int quiet = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) quiet++;
            else quiet = 0;
            if (quiet >= 4) return;
        end
        note_fail("idle_wait", "feeder stayed busy beyond its cycle budget");
    endtask

    task automatic wait_start(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (start) return;
        end
        note_fail("start_wait", "no start pulse within budget");
    endtask

    // Control-unit stand-in. A delay d answers done d cycles after the start cycle:
    // d=0 lands in ISSUE (ignored), 1..TIMEOUT land in WAIT_DONE (counted), -1 never answers.
    initial begin
        int d;
        bit counted;
        done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && start) begin
                if (delay_q.size() > 0) d = delay_q.pop_front();
                else if ($urandom_range(0, 7) == 0) d = TIMEOUT;
                else d = int'($urandom_range(1, 5));
                counted = (d >= 1) && (d <= TIMEOUT);
                if (counted) m_count = m_count + 8'd1;
                else m_err = 1'b1;
                resp_q.push_back('{idx: (counted ? d : TIMEOUT) + 1, cnt: m_count, flag: m_err});
                if (d >= 0) begin
                    repeat (d) @(negedge clk);
                    done = 1'b1;
                    @(negedge clk);
                    done = 1'b0;
                end
            end
        end
    end

    bit    trk        = 1'b0;
    int    trk_idx    = 0;
    logic  start_prev = 1'b0;
    pair_t last_pair;
    pair_t mp;
    resp_t mr;

    always @(negedge clk) begin
        if (!rst_n) begin
            trk        = 1'b0;
            start_prev = 1'b0;
        end else begin
            if (trk) begin
                trk_idx++;
                if (!busy) begin
                    if (resp_q.size() == 0) begin
                        note_fail("resp_expected", "busy period ended with no recorded transaction");
                    end else begin
                        mr = resp_q.pop_front();
                        check("busy_length", trk_idx, mr.idx);
                        check("pair_count", pair_count, mr.cnt);
                        check("err_flag", err, mr.flag);
                        check("hold_data_in1", data_in1, last_pair.a);
                        check("hold_data_in2", data_in2, last_pair.b);
                    end
                    trk = 1'b0;
                end else if (trk_idx > TIMEOUT + 4) begin
                    note_fail("busy_bound", "busy did not fall within TIMEOUT+4 cycles of start");
                    trk = 1'b0;
                end
            end
            if (start) begin
                starts_seen++;
                check("start_single_pulse", start_prev, 1'b0);
                if (exp_pairs.size() == 0) begin
                    note_fail("pair_expected", "start pulsed with fewer than two words accepted");
                end else begin
                    mp = exp_pairs.pop_front();
                    check("data_in1", data_in1, mp.a);
                    check("data_in2", data_in2, mp.b);
                    last_pair = mp;
                end
                trk     = 1'b1;
                trk_idx = 0;
            end
            start_prev = start;
        end
    end

    initial begin
        #(CLK_P * 50000);
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] w1;
        logic [DATA_W-1:0] w2;
        int s0;

        // Reset with in_valid held high.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'hA5A5;
        repeat (3) @(negedge clk);
        check("rst_start", start, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_pair_count", pair_count, 8'd0);
        check("rst_err", err, 1'b0);
        check("rst_data_in1", data_in1, 16'd0);
        check("rst_data_in2", data_in2, 16'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);

        // Basic pair with latency checks.
        delay_q.push_back(2);
        send(16'd5, 8);
        send(16'd6, 8);
        @(negedge clk);
        check("lat_busy_load1", busy, 1'b1);
        check("lat_no_early_start", start, 1'b0);
        @(negedge clk);
        check("lat_data_in1", data_in1, 16'd5);
        @(negedge clk);
        check("lat_start", start, 1'b1);
        check("lat_data_in2", data_in2, 16'd6);
        wait_idle(50);
        check("basic_pair_count", pair_count, 8'd1);
        check("basic_busy_low", busy, 1'b0);

        // Odd word waits for a partner.
        s0 = starts_seen;
        delay_q.push_back(3);
        send(16'h0011, 16);
        send(16'h0022, 16);
        send(16'h0033, 16);
        wait_idle(60);
        repeat (10) @(negedge clk);
        check("odd_one_pair", starts_seen - s0, 1);
        check("odd_word_idle", busy, 1'b0);
        send(16'h0044, 16);
        wait_idle(60);
        check("odd_second_pair", starts_seen - s0, 2);

        // Backpressure while a pair times out.
        delay_q.push_back(-1);
        send(16'h1001, 16);
        send(16'h1002, 16);
        wait_start(20);
        send(16'h1003, 4);
        send(16'h1004, 4);
        send(16'h1005, 4);
        send(16'h1006, 4);
        check("full_in_ready_low", in_ready, 1'b0);
        delay_q.push_back(1);
        delay_q.push_back(1);
        delay_q.push_back(1);
        send(16'h1007, 4 * TIMEOUT);
        send(16'h1008, 4 * TIMEOUT);
        wait_idle(8 * TIMEOUT);
        check("timeout_err_sticky", err, 1'b1);

        // Reset asserted in WAIT_DONE with a second pair buffered.
        delay_q.push_back(-1);
        send(16'h2001, 16);
        send(16'h2002, 16);
        send(16'h2003, 16);
        send(16'h2004, 16);
        wait_start(20);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_start", start, 1'b0);
        check("arst_err", err, 1'b0);
        check("arst_pair_count", pair_count, 8'd0);
        check("arst_data_in1", data_in1, 16'd0);
        check("arst_data_in2", data_in2, 16'd0);
        exp_pairs.delete();
        resp_q.delete();
        have_pend = 1'b0;
        m_count   = 8'd0;
        m_err     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("arst_fifo_empty_idle", busy, 1'b0);
        check("arst_in_ready", in_ready, 1'b1);

        // done on the last timeout cycle wins.
        delay_q.push_back(TIMEOUT);
        send(16'h3001, 16);
        send(16'h3002, 16);
        wait_idle(TIMEOUT + 30);
        check("coincide_err", err, 1'b0);
        check("coincide_count", pair_count, 8'd1);

        // done during ISSUE is ignored and the pair times out.
        delay_q.push_back(0);
        send(16'h4001, 16);
        send(16'h4002, 16);
        wait_idle(TIMEOUT + 30);
        check("issue_done_err", err, 1'b1);
        check("issue_done_count", pair_count, 8'd1);

        // Randomized traffic.
        for (int p = 0; p < 24; p++) begin
            w1 = DATA_W'($urandom);
            w2 = DATA_W'($urandom);
            send(w1, 4 * TIMEOUT);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(w2, 4 * TIMEOUT);
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        wait_idle(8 * TIMEOUT);
        check("pairs_drained", exp_pairs.size(), 0);
        check("resp_drained", resp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
